// File: rtl/wb_word_fifo_pkg.sv
// Shared definitions for the Wishbone word FIFO slave:
// status word bit positions, select constant and a log2 helper.
package wb_word_fifo_pkg;

    localparam int ST_FULL    = 31;
    localparam int ST_EMPTY   = 30;
    localparam int ST_OVF     = 29;
    localparam int ST_LVL_MSB = 8;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    // Ceiling log2, valid for value >= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sfifo_fwft.sv
// Synchronous first-word-fall-through FIFO, async active-high reset.
// Ports: clk_i, rst_i; push_i/data_i write side; pop_i read side;
//        data_o head word, level_o current fill, level_nxt_o fill
//        after this edge, full_o, empty_o.
module sfifo_fwft
    import wb_word_fifo_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [LW-1:0]    level_o,
    output logic [LW-1:0]    level_nxt_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);

    // Push is qualified by the registered level, so a full FIFO
    // refuses a write even when a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: level gates visibility of every entry.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o      = mem_q[rptr_q];
    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule

// File: rtl/wb_word_fifo_slave.sv
// Pipelined Wishbone slave: writes push a word into a FWFT FIFO,
// reads return a status word; FIFO drains through a valid/ready stream.
// Ports: clk_i, rst_i; wb_* Wishbone slave side (no address);
//        tx_data_o/tx_valid_o/tx_ready_i output stream; irq_o fill irq.
module wb_word_fifo_slave
    import wb_word_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int THRESH = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        wb_stall_o,
    output logic [31:0] wb_dat_o,
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        irq_o
);

    localparam int LW = clog2(DEPTH) + 1;
    localparam int SW = ST_LVL_MSB + 1;

    localparam logic [LW-1:0] THRESH_L = LW'(THRESH);

    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;

    logic          acc;
    logic          wr_acc;
    logic          rd_acc;
    logic          sel_ok;
    logic          push;
    logic          wr_ovf;
    logic [31:0]   status;

    logic [31:0]   fifo_data;
    logic [LW-1:0] fifo_level;
    logic [LW-1:0] fifo_level_nxt;
    logic          fifo_full;
    logic          fifo_empty;

    sfifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .data_i      (wb_dat_i),
        .pop_i       (tx_ready_i),
        .data_o      (fifo_data),
        .level_o     (fifo_level),
        .level_nxt_o (fifo_level_nxt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // A strobe still high during its own response cycle is not
    // accepted a second time.
    assign acc    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign wr_acc = acc & wb_we_i;
    assign rd_acc = acc & ~wb_we_i;
    assign sel_ok = (wb_sel_i == SEL_ALL);
    assign push   = wr_acc & sel_ok & ~fifo_full;
    assign wr_ovf = wr_acc & sel_ok & fifo_full;

    always_comb begin
        status                 = '0;
        status[ST_FULL]        = fifo_full;
        status[ST_EMPTY]       = fifo_empty;
        status[ST_OVF]         = ovf_q;
        status[ST_LVL_MSB:0]   = SW'(fifo_level);
    end

    always_comb begin
        ack_d = push | rd_acc;
        err_d = wr_acc & ~push;
        dat_d = dat_q;
        ovf_d = ovf_q;
        irq_d = (fifo_level_nxt >= THRESH_L);
        if (rd_acc) begin
            dat_d = status;
            ovf_d = 1'b0;
        end
        // Setting wins over a same-cycle read clear.
        if (wr_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            ovf_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            dat_q <= dat_d;
            ovf_q <= ovf_d;
            irq_q <= irq_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_rty_o   = 1'b0;
    assign wb_dat_o   = dat_q;
    assign wb_stall_o = wb_cyc_i & wb_stb_i & ~(ack_q | err_q);

    assign tx_data_o  = fifo_data;
    assign tx_valid_o = ~fifo_empty;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_word_fifo_slave.sv
// Self-checking bench for wb_word_fifo_slave: queue-based model
// compared every cycle plus directed literal expectations.
module tb_wb_word_fifo_slave;

    localparam int DEPTH  = 16;
    localparam int THRESH = 12;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic        wb_stall_o;
    logic [31:0] wb_dat_o;
    logic [31:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    wb_word_fifo_slave #(
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_rty_o   (wb_rty_o),
        .wb_stall_o (wb_stall_o),
        .wb_dat_o   (wb_dat_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] mq[$];
    logic [31:0] rx[$];
    bit          m_ovf;
    bit          m_ack;
    bit          m_err;
    logic [31:0] m_dat;
    bit          m_acc;
    bit          m_pop;
    bit          m_push;
    bit          n_ack;
    bit          n_err;

    function automatic logic [31:0] status_of(input int lvl, input bit ovf);
        logic [31:0] s;
        s = 32'(lvl);
        if (lvl == DEPTH) s = s | 32'h8000_0000;
        if (lvl == 0)     s = s | 32'h4000_0000;
        if (ovf)          s = s | 32'h2000_0000;
        return s;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mq.delete();
            m_ovf = 1'b0;
            m_ack = 1'b0;
            m_err = 1'b0;
            m_dat = '0;
        end else begin
            m_acc  = wb_cyc_i && wb_stb_i && !m_ack && !m_err;
            m_pop  = (mq.size() != 0) && tx_ready_i;
            m_push = 1'b0;
            n_ack  = 1'b0;
            n_err  = 1'b0;
            if (m_acc && wb_we_i) begin
                if (wb_sel_i == 4'hF && mq.size() < DEPTH) begin
                    m_push = 1'b1;
                    n_ack  = 1'b1;
                end else begin
                    n_err = 1'b1;
                    if (wb_sel_i == 4'hF) m_ovf = 1'b1;
                end
            end else if (m_acc) begin
                n_ack = 1'b1;
                m_dat = status_of(mq.size(), m_ovf);
                m_ovf = 1'b0;
            end
            m_ack = n_ack;
            m_err = n_err;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(wb_dat_i);
        end
    end

    // Words actually handed out on the stream.
    always @(posedge clk_i) begin
        if (!rst_i && tx_valid_o === 1'b1 && tx_ready_i) begin
            rx.push_back(tx_data_o);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk_i) begin
        if (!rst_i && $time > 20) begin
            chk("ack", 32'(wb_ack_o), 32'(m_ack));
            chk("err", 32'(wb_err_o), 32'(m_err));
            chk("rty", 32'(wb_rty_o), 32'd0);
            chk("dat_o", wb_dat_o, m_dat);
            chk("stall", 32'(wb_stall_o),
                32'(wb_cyc_i && wb_stb_i && !(m_ack || m_err)));
            chk("tx_valid", 32'(tx_valid_o), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("tx_data", tx_data_o, mq[0]);
            chk("irq", 32'(irq_o), 32'(mq.size() >= THRESH));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wb_xfer(input bit we, input logic [3:0] sel,
                           input logic [31:0] dat, input bit exp_ack,
                           output logic [31:0] rdata);
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_dat_i = dat;
        #1;
        chk("stall_accept", 32'(wb_stall_o), 32'd1);
        chk("ack_early", 32'(wb_ack_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("xfer_ack", 32'(wb_ack_o), 32'(exp_ack));
        chk("xfer_err", 32'(wb_err_o), 32'(!exp_ack));
        chk("stall_resp", 32'(wb_stall_o), 32'd0);
        rdata = wb_dat_o;
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'h0;
    endtask

    logic [31:0] rd;

    initial begin
        #1 rst_i = 1'b1;
        #20;
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        wb_xfer(1'b0, 4'hF, '0, 1'b1, rd);
        chk("status_reset", rd, 32'h4000_0000);

        wb_xfer(1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, rd);
        chk("wr_valid", 32'(tx_valid_o), 32'd1);
        chk("wr_head", tx_data_o, 32'hDEAD_BEEF);
        wb_xfer(1'b0, 4'hF, '0, 1'b1, rd);
        chk("status_lvl1", rd, 32'h0000_0001);

        rx.delete();
        tx_ready_i = 1'b1;
        @(posedge clk_i);
        #1 tx_ready_i = 1'b0;
        chk("pop_one_cnt", 32'(rx.size()), 32'd1);
        if (rx.size() == 1) chk("pop_one_val", rx[0], 32'hDEAD_BEEF);

        wb_xfer(1'b1, 4'h3, 32'h1234_5678, 1'b0, rd);
        wb_xfer(1'b0, 4'hF, '0, 1'b1, rd);
        chk("status_partial", rd, 32'h4000_0000);

        for (int i = 0; i < DEPTH; i++) begin
            wb_xfer(1'b1, 4'hF, 32'(i), 1'b1, rd);
            if (i == THRESH - 2) chk("irq_below", 32'(irq_o), 32'd0);
            if (i == THRESH - 1) chk("irq_at", 32'(irq_o), 32'd1);
        end
        wb_xfer(1'b1, 4'hF, 32'h0000_0063, 1'b0, rd);
        wb_xfer(1'b0, 4'hF, '0, 1'b1, rd);
        chk("status_ovf", rd, 32'hA000_0010);
        wb_xfer(1'b0, 4'hF, '0, 1'b1, rd);
        chk("status_ovf_clr", rd, 32'h8000_0010);

        rx.delete();
        @(posedge clk_i);
        #1 tx_ready_i = 1'b1;
        repeat (DEPTH + 2) @(posedge clk_i);
        #1 tx_ready_i = 1'b0;
        chk("drain_valid", 32'(tx_valid_o), 32'd0);
        chk("drain_irq", 32'(irq_o), 32'd0);
        chk("drain_cnt", 32'(rx.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < rx.size(); i++) begin
            chk("drain_order", rx[i], 32'(i));
        end

        rx.delete();
        tx_ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wb_xfer(1'b1, 4'hF, 32'h1000_0000 + 32'(i), 1'b1, rd);
            if (i == 25) begin
                rst_i = 1'b1;
                #1;
                chk("midrst_valid", 32'(tx_valid_o), 32'd0);
                chk("midrst_ack", 32'(wb_ack_o), 32'd0);
                @(posedge clk_i);
                #1 rst_i = 1'b0;
                wb_xfer(1'b0, 4'hF, '0, 1'b1, rd);
                chk("midrst_status", rd, 32'h4000_0000);
            end
        end
        repeat (2) @(posedge clk_i);
        #1 tx_ready_i = 1'b0;
        chk("wrap_cnt", 32'(rx.size()), 32'd40);
        for (int i = 0; i < 40 && i < rx.size(); i++) begin
            chk("wrap_order", rx[i], 32'h1000_0000 + 32'(i));
        end
        wb_xfer(1'b0, 4'hF, '0, 1'b1, rd);
        chk("status_end", rd, 32'h4000_0000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_word_fifo_slave.md
Name: wb_word_fifo_slave

Overview:
- Single-word pipelined Wishbone slave that sits directly downstream of a generated register block's submap master port (cyc/stb/sel/we/dat, ack/err/rty/stall, no address lines).
- A WB write pushes a 32-bit word into an internal FIFO. A WB read returns a status word.
- FIFO contents drain through a first-word-fall-through valid/ready stream toward the datapath.
- Provides a fill-threshold interrupt.

Parameters:
DEPTH  16  FIFO depth in words; power of two, 2..256
THRESH  12  irq_o asserts when level >= THRESH; 1..DEPTH

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
wb_cyc_i  in  1  WB cycle
wb_stb_i  in  1  WB strobe; master holds it high until ack/err
wb_sel_i  in  4  byte selects
wb_we_i  in  1  1 = write (push), 0 = read (status)
wb_dat_i  in  32  write data
wb_ack_o  out  1  transfer acknowledge
wb_err_o  out  1  transfer error
wb_rty_o  out  1  tied 0
wb_stall_o  out  1  pipelined stall
wb_dat_o  out  32  read data (status)
tx_data_o  out  32  FIFO head word
tx_valid_o  out  1  FIFO non-empty
tx_ready_i  in  1  consumer pops the head when valid & ready
irq_o  out  1  level >= THRESH, registered

Behaviour:
- Reset (rst_i high, asynchronous) clears the following:
  - FIFO pointers and level = 0; overflow sticky = 0.
  - wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, irq_o = 0.
  - Result: tx_valid_o = 0 and wb_stall_o follows its equation.
- Accept: acc = wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o.
  - This prevents re-accepting a strobe that is still high in the response cycle.
- Response latency is exactly 1 cycle.
  - Exactly one of ack/err pulses high for one cycle, on the clock edge after acc.
  - wb_stall_o = wb_cyc_i & wb_stb_i & !(wb_ack_o | wb_err_o), combinational.
- Write (acc & wb_we_i):
  - Push wb_dat_i when wb_sel_i = 4'b1111 and registered level != DEPTH, then ack.
  - Level is sampled before any same-cycle pop, so a full FIFO rejects the push even if a pop occurs in that cycle.
  - Full FIFO: err, no push, overflow sticky set.
  - Partial sel (not 4'b1111): err, no push, sticky unchanged.
- Read (acc & !wb_we_i): ack; wb_dat_o registered in the same cycle as ack.
  - [31] full, [30] empty, [29] overflow sticky, [28:9] 0, [8:0] level (zero-extended).
  - The read clears the overflow sticky on that edge. If an overflow sets it in the same cycle, set wins. Reads and writes never coincide (single master), so this is by construction.
- Pop: when tx_valid_o & tx_ready_i, advance the read pointer.
- Simultaneous push and pop: level unchanged, both pointers advance.
  - Push into an empty FIFO: tx_valid_o rises the next cycle, and tx_data_o then shows the pushed word.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Level is log2(DEPTH)+1 bits, range 0..DEPTH.
  - full = (level == DEPTH); empty = (level == 0).
- irq_o is registered from the next-state level: it goes high on the same edge that makes level >= THRESH, and low on the edge that makes level < THRESH.
- wb_dat_o holds its last value when not acking.
- wb_cyc_i dropped mid-transfer: an accepted request still completes. Ack/err is emitted and the push/pop side effect happens; the master ignores it.
- Reset asserted mid-transfer: the pending ack is lost and FIFO contents are discarded.

Decomposition:
- Shared package wb_word_fifo_pkg:
  - Status bit positions (ST_FULL = 31, ST_EMPTY = 30, ST_OVF = 29, ST_LVL_MSB = 8).
  - Function clog2.
- Sub-module sfifo_fwft(DEPTH, WIDTH):
  - Synchronous FWFT FIFO with push/pop/data/level/full/empty and asynchronous active-high reset.
  - The top level holds only the WB handshake, status mux, sticky and irq logic.

Test Plan:
- Reset then read: status = 0x4000_0000 (empty), ack exactly 1 cycle after the accept edge, stall high only during the accept cycle.
- Write 0xDEAD_BEEF with sel = 4'hF, tx_ready_i = 0: ack; tx_valid_o = 1 and tx_data_o = 0xDEAD_BEEF the next cycle; status level = 1.
- Write 16 words (DEPTH = 16) with tx_ready_i = 0: irq_o rises on the 12th push's edge; 17th write → err; status = 0xA000_0010. A second status read returns 0x8000_0010 (sticky cleared).
- Write with sel = 4'h3: err, level unchanged, overflow bit stays 0.
- FIFO full with tx_ready_i = 1 held: 16 pops in order (first-in first out, values 0..15), tx_valid_o falls after the last pop, irq_o falls when level goes 12→11.
- Continuous push each transfer with tx_ready_i = 1 across pointer wrap (40 words): output order is preserved and level never exceeds 1; assert rst_i mid-stream → tx_valid_o = 0 and status empty immediately.
